// File: rtl/debounce_pkg.sv
// Shared defaults, level type and counter sizing helper for the multi-channel debouncer.
package debounce_pkg;

  localparam int unsigned DEF_N_CH          = 5;
  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY  = 32500000;
  localparam int unsigned DEF_REPEAT_PERIOD = 6500000;

  typedef enum logic {LVL_LOW, LVL_HIGH} level_t;

  // Bits needed to hold any value 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, stability filter, rise/fall strobes and optional
// auto-repeat press strobes (enabled by defining MULTI_DEBOUNCE_REPEAT_EN).
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic noisy_in,
  output logic clean_out,
  output logic rise_out,
  output logic fall_out,
  output logic press_out
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CntLast = CW'(STABLE_CYCLES - 1);

  if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_bad_param
    $error("debounce_chan: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  level_t                 r_cand;
  level_t                 r_clean;
  logic [CW-1:0]          r_cnt;
  logic                   r_rise;
  logic                   r_fall;

  level_t w_s;
  logic   w_settled;
  logic   w_rise_evt;
  logic   w_fall_evt;

  assign w_s        = level_t'(r_sync[SYNC_STAGES-1]);
  assign w_settled  = (w_s == r_cand) && (r_cnt == CntLast);
  assign w_rise_evt = w_settled && (r_cand == LVL_HIGH) && (r_clean == LVL_LOW);
  assign w_fall_evt = w_settled && (r_cand == LVL_LOW) && (r_clean == LVL_HIGH);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_sync  <= '0;
      r_cand  <= LVL_LOW;
      r_cnt   <= '0;
      r_clean <= LVL_LOW;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], noisy_in};
      r_rise <= w_rise_evt;
      r_fall <= w_fall_evt;
      if (w_s != r_cand) begin
        r_cand <= w_s;
        r_cnt  <= '0;
      end else if (r_cnt == CntLast) begin
        // Counter saturates here; clean simply tracks the settled candidate.
        if (r_clean != r_cand) r_clean <= r_cand;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign clean_out = (r_clean == LVL_HIGH);
  assign rise_out  = r_rise;
  assign fall_out  = r_fall;

`ifdef MULTI_DEBOUNCE_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW = cnt_width(RepMax);
  localparam logic [RW-1:0] DelayLast  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PeriodLast = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_first;
  logic          r_rep_pulse;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
      r_rep_pulse <= 1'b0;
    end else if (w_rise_evt) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
      r_rep_pulse <= 1'b0;
    end else if ((r_clean == LVL_HIGH) && !w_fall_evt) begin
      // First interval is the long hold delay, later ones the repeat period.
      if (r_rep_cnt == (r_rep_first ? DelayLast : PeriodLast)) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b0;
        r_rep_pulse <= 1'b1;
      end else begin
        r_rep_cnt   <= r_rep_cnt + RW'(1);
        r_rep_pulse <= 1'b0;
      end
    end else begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
      r_rep_pulse <= 1'b0;
    end
  end

  assign press_out = r_rise | r_rep_pulse;
`else
  assign press_out = r_rise;
`endif

endmodule

// File: rtl/multi_debounce.sv
// N independent debounce channels; define MULTI_DEBOUNCE_REPEAT_EN for auto-repeat presses.
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH          = DEF_N_CH,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out,
  output logic [N_CH-1:0] press_out
);

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .noisy_in (noisy_in[g]),
      .clean_out(clean_out[g]),
      .rise_out (rise_out[g]),
      .fall_out (fall_out[g]),
      .press_out(press_out[g])
    );
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Scoreboard bench for multi_debounce: stimulus schedules expected strobes, a monitor checks them.
module tb_multi_debounce;

  localparam int LAT = 6;   // SYNC_STAGES + STABLE_CYCLES
  localparam int RD  = 10;
  localparam int RP  = 3;

  typedef struct {
    int         cyc;
    logic [2:0] rise;
    logic [2:0] fall;
    logic [2:0] press;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] noisy;
  logic [2:0] clean_out, rise_out, fall_out, press_out;

  int   e = 0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t q[$];

  multi_debounce #(
    .N_CH         (3),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .noisy_in (noisy),
    .clean_out(clean_out),
    .rise_out (rise_out),
    .fall_out (fall_out),
    .press_out(press_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) e <= e + 1;

  // Sorted insert; events landing on the same edge are merged.
  function automatic void ins(input int cyc, input logic [2:0] r, input logic [2:0] f,
                              input logic [2:0] p);
    exp_t it;
    it.cyc = cyc; it.rise = r; it.fall = f; it.press = p;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc == cyc) begin
        q[i].rise  = q[i].rise | r;
        q[i].fall  = q[i].fall | f;
        q[i].press = q[i].press | p;
        return;
      end
      if (q[i].cyc > cyc) begin
        q.insert(i, it);
        return;
      end
    end
    q.push_back(it);
  endfunction

  // Raw high captured at c_on, low captured at c_off.
  function automatic void sched(input logic [2:0] m, input int c_on, input int c_off);
    int r;
    int f;
    r = c_on + LAT;
    f = c_off + LAT;
    ins(r, m, 3'b000, m);
`ifdef MULTI_DEBOUNCE_REPEAT_EN
    for (int t = r + RD; t < f; t += RP) ins(t, 3'b000, 3'b000, m);
`endif
    ins(f, 3'b000, m, 3'b000);
  endfunction

  // Called at a negedge; returns the edge that will capture the new value.
  task automatic set_raw(input logic [2:0] v, output int c);
    noisy = v;
    c = e + 1;
  endtask

  task automatic wait_until(input int c);
    while (e < c) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: cycle %0d got %h want %h", name, e, act, want);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t x;
    while (q.size() > 0 && q[0].cyc < e) begin
      nvec++;
      nerr++;
      $display("FAIL missing_event: cycle %0d no strobe, want rise=%b fall=%b press=%b",
               q[0].cyc, q[0].rise, q[0].fall, q[0].press);
      void'(q.pop_front());
    end
    if ((rise_out | fall_out | press_out) != 3'b000) begin
      nvec++;
      if (q.size() == 0 || q[0].cyc != e) begin
        nerr++;
        $display("FAIL unexpected_event: cycle %0d got rise=%b fall=%b press=%b, want none",
                 e, rise_out, fall_out, press_out);
      end else begin
        x = q.pop_front();
        if (rise_out !== x.rise || fall_out !== x.fall || press_out !== x.press) begin
          nerr++;
          $display("FAIL strobe_cmp: cycle %0d got rise=%b fall=%b press=%b want %b %b %b",
                   e, rise_out, fall_out, press_out, x.rise, x.fall, x.press);
        end
      end
    end
`ifndef MULTI_DEBOUNCE_REPEAT_EN
    nvec++;
    if (press_out !== rise_out) begin
      nerr++;
      $display("FAIL press_eq_rise: cycle %0d got press=%b want %b", e, press_out, rise_out);
    end
`endif
  end

  initial begin
    int c;
    rst_n = 1'b0;
    noisy = 3'b000;
    repeat (3) @(negedge clk);
    chk("reset_state", {clean_out, rise_out, fall_out, press_out}, 12'h000);
    rst_n = 1'b1;
    wait_until(e + 8);
    chk("idle_low", {9'd0, clean_out}, 12'h000);

    // Ch0 rise then release.
    set_raw(3'b001, c);
    sched(3'b001, c, c + 20);
    wait_until(c + 5);  chk("s1_clean_pre",  {11'd0, clean_out[0]}, 12'h000);
    wait_until(c + 6);  chk("s1_clean_post", {11'd0, clean_out[0]}, 12'h001);
    wait_until(c + 19); set_raw(3'b000, c);
    wait_until(c + 5);  chk("s3_clean_pre",  {11'd0, clean_out[0]}, 12'h001);
    wait_until(c + 6);  chk("s3_clean_post", {11'd0, clean_out[0]}, 12'h000);
    wait_until(c + 12);

    // Ch1 bounces in 3-cycle segments, then holds high.
    set_raw(3'b010, c);
    for (int k = 1; k <= 4; k++) begin
      wait_until(c + 3 * k - 1);
      noisy = (k % 2 == 0) ? 3'b010 : 3'b000;
    end
    sched(3'b010, c + 12, c + 28);
    wait_until(c + 17); chk("s2_clean_pre",  {11'd0, clean_out[1]}, 12'h000);
    wait_until(c + 18); chk("s2_clean_post", {11'd0, clean_out[1]}, 12'h001);
    wait_until(c + 27); noisy = 3'b000;
    wait_until(c + 40);

    // All channels together.
    set_raw(3'b111, c);
    sched(3'b111, c, c + 8);
    wait_until(c + 6);  chk("s4_clean_all", {9'd0, clean_out}, 12'h007);
    wait_until(c + 7);  noisy = 3'b000;
    wait_until(c + 14); chk("s4_clean_none", {9'd0, clean_out}, 12'h000);
    wait_until(c + 20);

    // Reset mid-count with raw held high.
    set_raw(3'b001, c);
    wait_until(c + 3);  rst_n = 1'b0;
    wait_until(c + 5);
    chk("s5_in_reset", {clean_out, rise_out, fall_out, press_out}, 12'h000);
    rst_n = 1'b1;
    sched(3'b001, c + 6, c + 18);
    wait_until(c + 11); chk("s5_clean_pre",  {11'd0, clean_out[0]}, 12'h000);
    wait_until(c + 12); chk("s5_clean_post", {11'd0, clean_out[0]}, 12'h001);
    wait_until(c + 17); noisy = 3'b000;
    wait_until(c + 30);

    // Ch2 long hold exercises auto-repeat.
    set_raw(3'b100, c);
    sched(3'b100, c, c + 20);
    wait_until(c + 19); noisy = 3'b000;
    wait_until(c + 32);
    chk("final_clean", {9'd0, clean_out}, 12'h000);

    while (q.size() > 0) begin
      nvec++;
      nerr++;
      $display("FAIL leftover_event: expected cycle %0d rise=%b fall=%b press=%b never seen",
               q[0].cyc, q[0].rise, q[0].fall, q[0].press);
      void'(q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
